inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Assembles abstract instruction commands (kind plus register, immediate and target fields) into 32-bit MIPS machine words for the single-cycle CPU's instruction memory.
- It is the inverse of the control decoder: it covers the same instruction set the CPU decodes.
- Encoded words are buffered in a small FIFO and emitted on a ready/valid stream, each tagged with its instruction-memory byte address.
- Used by the program loader and by self-checking benches.

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000: byte address of the first emitted word after reset or clr; must be word-aligned.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- clr  input  1  synchronous flush: empties the FIFO and rewinds both address counters to BASE_ADDR; sticky errors are kept.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted this cycle when high together with cmd_valid.
- cmd_kind  input  5  instruction kind code (package enum).
- cmd_rs, cmd_rt, cmd_rd, cmd_shamt  input  5 each  register and shift-amount fields.
- cmd_imm  input  16  immediate or branch offset.
- cmd_target  input  32  byte address; j/jal use bits [27:2].
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer takes the head word.
- out_word  output  32  encoded instruction.
- out_addr  output  32  byte address for out_word.
- level  output  $clog2(DEPTH)+1  FIFO occupancy.
- err_illegal  output  1  sticky: an unknown cmd_kind was accepted.
- err_range  output  1  sticky: branch range error (optional feature only; otherwise tied to 0).

Behaviour:
- Reset (rst=1): FIFO empty, level=0, out_valid=0, out_word=0, out_addr=BASE_ADDR, wr_pc=BASE_ADDR, err_illegal=0, err_range=0.
  - rst has priority over clr; clr has priority over push/pop in the same cycle.
- cmd_ready = (level < DEPTH) && !clr.
  - It depends only on registered state: no combinational path from out_ready, so no push happens while full even if a pop occurs in the same cycle.
- Push: on accept, the combinational encoding is written to the FIFO tail and wr_pc advances by 4.
  - An illegal kind is still accepted (handshake completes), sets err_illegal, and is not pushed; wr_pc does not advance.
- Pop: when out_valid && out_ready, the head is removed and out_addr advances by 4.
  - Both address counters wrap modulo 2^32.
- Simultaneous push and pop: level unchanged, and both take effect.
- Latency: a command accepted in cycle N appears as the FIFO head (out_valid=1) in cycle N+1 when the FIFO was empty. Throughput is one word per cycle.
- out_word and out_addr are stable while out_valid=1 and out_ready=0.
- R-type encodings (op=0):
  - add/sub/and/or/xor: funct 0x20/0x22/0x24/0x25/0x26 from rs, rt, rd; shamt=0.
  - sll/srl/sra: funct 0x00/0x02/0x03 from rt, rd, shamt; rs=0.
  - jr: funct 0x08 from rs; rt, rd and shamt are 0.
- I-type encodings: word = op | rs<<21 | rt<<16 | imm.
  - addi 0x08, andi 0x0C, ori 0x0D, xori 0x0E, lw 0x23, sw 0x2B, beq 0x04, bne 0x05.
  - lui 0x0F forces rs=0.
- J-type encodings: j 0x02, jal 0x03, with field = cmd_target[27:2].
- Unused input fields are ignored and never leak into the word.
- clr while out_valid=1: the head is discarded; out_valid=0 in the next cycle.

Optional Feature:
- Macro: INST_ENC_BRANCH_ABS_EN.
- Defined:
  - For beq/bne, cmd_target is an absolute byte address.
  - offset = (cmd_target - (wr_pc + 4)) >>> 2, arithmetic, 32-bit.
  - The imm field is offset[15:0].
  - If cmd_target[1:0] != 0, or offset lies outside [-32768, 32767], err_range is set; the word is still pushed with the truncated offset.
- Undefined: beq/bne use cmd_imm directly, and err_range is constant 0.

Decomposition:
- Package inst_enc_pkg holds:
  - the kind enum: ADD=0, SUB, AND, OR, XOR, SLL, SRL, SRA, JR, ADDI, ANDI, ORI, XORI, LW, SW, BEQ, BNE, LUI, J, JAL=19; codes 20-31 are illegal;
  - the opcode and funct localparams;
  - the word layout field positions.
- One sub-module, inst_enc_fifo: parameterised synchronous FIFO with push, pop, clr and level. The encoder itself is the combinational encode function plus the address and error registers.

Test Plan:
- After reset: push ADD rs=1 rt=2 rd=3 -> out_word=0x00221820, out_addr=0x0, out_valid high exactly one cycle after accept.
- Back-to-back ADDI rt=2 rs=0 imm=5, then SLL rd=4 rt=2 shamt=3 with rs=7 (rs must be ignored), then LW rt=5 rs=6 imm=8 -> words 0x20020005, 0x000220C0, 0x8CC50008 at addresses 0x0, 0x4, 0x8.
- J cmd_target=0x00400020 -> 0x08100008. Kind 25 -> err_illegal=1, no push, level unchanged.
- Hold out_ready=0 and push DEPTH+1 commands -> cmd_ready drops at level=DEPTH, the head stays stable, and draining returns words in order. A simultaneous push and pop at level 2 keeps level=2.
- clr asserted with 3 entries queued -> level=0 and out_valid=0 next cycle; the next push is emitted at BASE_ADDR; err flags are retained.
- INST_ENC_BRANCH_ABS_EN: after two pushes, BEQ rs=1 rt=2 target=0x4 -> 0x1022FFFE; target=0x40000 -> err_range=1; target=0x6 -> err_range=1.

Source files
------------

// File: rtl/inst_enc_pkg.sv
// Shared definitions for the MIPS instruction encoder: kind codes, opcode/funct
// values, word field positions and the combinational encode function.
package inst_enc_pkg;

  typedef enum logic [4:0] {
    K_ADD  = 5'd0,  K_SUB  = 5'd1,  K_AND  = 5'd2,  K_OR   = 5'd3,
    K_XOR  = 5'd4,  K_SLL  = 5'd5,  K_SRL  = 5'd6,  K_SRA  = 5'd7,
    K_JR   = 5'd8,  K_ADDI = 5'd9,  K_ANDI = 5'd10, K_ORI  = 5'd11,
    K_XORI = 5'd12, K_LW   = 5'd13, K_SW   = 5'd14, K_BEQ  = 5'd15,
    K_BNE  = 5'd16, K_LUI  = 5'd17, K_J    = 5'd18, K_JAL  = 5'd19
  } kind_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;

  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int SH_LSB = 6;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

  function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [4:0] sh, logic [5:0] fn);
    return (32'(OP_RTYPE) << OP_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB)
         | (32'(rd) << RD_LSB) | (32'(sh) << SH_LSB) | 32'(fn);
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return (32'(op) << OP_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) | 32'(imm);
  endfunction

  function automatic logic [31:0] jtype(logic [5:0] op, logic [31:0] target);
    return (32'(op) << OP_LSB) | {6'd0, target[27:2]};
  endfunction

  // Fields a kind does not use are replaced by zero so they never leak into the word.
  function automatic enc_t encode(logic [4:0] kind, logic [4:0] rs, logic [4:0] rt,
                                  logic [4:0] rd, logic [4:0] sh, logic [15:0] imm,
                                  logic [31:0] target);
    enc_t e;
    e.legal = 1'b1;
    e.word  = 32'h0000_0000;
    case (kind)
      K_ADD:   e.word = rtype(rs, rt, rd, 5'd0, FN_ADD);
      K_SUB:   e.word = rtype(rs, rt, rd, 5'd0, FN_SUB);
      K_AND:   e.word = rtype(rs, rt, rd, 5'd0, FN_AND);
      K_OR:    e.word = rtype(rs, rt, rd, 5'd0, FN_OR);
      K_XOR:   e.word = rtype(rs, rt, rd, 5'd0, FN_XOR);
      K_SLL:   e.word = rtype(5'd0, rt, rd, sh, FN_SLL);
      K_SRL:   e.word = rtype(5'd0, rt, rd, sh, FN_SRL);
      K_SRA:   e.word = rtype(5'd0, rt, rd, sh, FN_SRA);
      K_JR:    e.word = rtype(rs, 5'd0, 5'd0, 5'd0, FN_JR);
      K_ADDI:  e.word = itype(OP_ADDI, rs, rt, imm);
      K_ANDI:  e.word = itype(OP_ANDI, rs, rt, imm);
      K_ORI:   e.word = itype(OP_ORI, rs, rt, imm);
      K_XORI:  e.word = itype(OP_XORI, rs, rt, imm);
      K_LW:    e.word = itype(OP_LW, rs, rt, imm);
      K_SW:    e.word = itype(OP_SW, rs, rt, imm);
      K_BEQ:   e.word = itype(OP_BEQ, rs, rt, imm);
      K_BNE:   e.word = itype(OP_BNE, rs, rt, imm);
      K_LUI:   e.word = itype(OP_LUI, 5'd0, rt, imm);
      K_J:     e.word = jtype(OP_J, target);
      K_JAL:   e.word = jtype(OP_JAL, target);
      default: e.legal = 1'b0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/inst_enc_fifo.sv
// Synchronous FIFO with flush and occupancy; output data reads as zero when empty.
module inst_enc_fifo
  import inst_enc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic                       out_valid,
  output logic [W-1:0]               out_data,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign do_push_s = push && (level_r != LW'(DEPTH));
  assign do_pop_s  = pop && (level_r != {LW{1'b0}});

  // Pointer and occupancy bookkeeping; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else if (clr) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Storage write; contents need no reset because the read side is gated by occupancy.
  always_ff @(posedge clk) begin
    if (do_push_s && !clr && !rst) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign out_valid = (level_r != {LW{1'b0}});
  assign out_data  = out_valid ? mem_r[rd_ptr_r] : {W{1'b0}};
  assign level     = level_r;

endmodule

// File: rtl/inst_encoder.sv
// MIPS instruction encoder: encodes commands, queues words and tags them with byte addresses.
// Optional macro INST_ENC_BRANCH_ABS_EN turns beq/bne targets into absolute byte addresses.
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [4:0]             cmd_kind,
  input  logic [4:0]             cmd_rs,
  input  logic [4:0]             cmd_rt,
  input  logic [4:0]             cmd_rd,
  input  logic [4:0]             cmd_shamt,
  input  logic [15:0]            cmd_imm,
  input  logic [31:0]            cmd_target,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_word,
  output logic [31:0]            out_addr,
  output logic [$clog2(DEPTH):0] level,
  output logic                   err_illegal,
  output logic                   err_range
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic [31:0] wr_pc_r;
  logic [31:0] rd_pc_r;
  logic        err_illegal_r;
  logic [15:0] imm_s;
  enc_t        enc_s;
  logic        accept_s;
  logic        push_s;
  logic        pop_s;

`ifdef INST_ENC_BRANCH_ABS_EN
  logic        is_branch_s;
  logic [31:0] diff_s;
  logic [31:0] offset_s;
  logic        range_bad_s;
  logic        err_range_r;

  // Branch offset is relative to the word after the branch, which is the branch's wr_pc + 4.
  always_comb begin
    is_branch_s = (cmd_kind == K_BEQ) || (cmd_kind == K_BNE);
    diff_s      = cmd_target - wr_pc_r - 32'd4;
    offset_s    = $signed(diff_s) >>> 2;
    if (is_branch_s) begin
      imm_s       = offset_s[15:0];
      range_bad_s = (cmd_target[1:0] != 2'b00) || (offset_s[31:15] != {17{offset_s[15]}});
    end else begin
      imm_s       = cmd_imm;
      range_bad_s = 1'b0;
    end
  end

  // Sticky range error; survives clr so the loader can report it after a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_range_r <= 1'b0;
    end else if (accept_s && enc_s.legal && range_bad_s) begin
      err_range_r <= 1'b1;
    end else begin
      err_range_r <= err_range_r;
    end
  end

  assign err_range = err_range_r;
`else
  assign imm_s     = cmd_imm;
  assign err_range = 1'b0;
`endif

  assign enc_s     = encode(cmd_kind, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, imm_s, cmd_target);
  assign cmd_ready = (level < LW'(DEPTH)) && !clr;
  assign accept_s  = cmd_valid && cmd_ready;
  assign push_s    = accept_s && enc_s.legal;
  assign pop_s     = out_valid && out_ready;

  // Write/read address counters and the sticky illegal-kind flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_pc_r       <= BASE_ADDR;
      rd_pc_r       <= BASE_ADDR;
      err_illegal_r <= 1'b0;
    end else if (clr) begin
      wr_pc_r       <= BASE_ADDR;
      rd_pc_r       <= BASE_ADDR;
      err_illegal_r <= err_illegal_r;
    end else begin
      if (push_s) wr_pc_r <= wr_pc_r + 32'd4;
      if (pop_s)  rd_pc_r <= rd_pc_r + 32'd4;
      if (accept_s && !enc_s.legal) err_illegal_r <= 1'b1;
    end
  end

  inst_enc_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .push      (push_s),
    .push_data (enc_s.word),
    .pop       (pop_s),
    .out_valid (out_valid),
    .out_data  (out_word),
    .level     (level)
  );

  assign out_addr    = rd_pc_r;
  assign err_illegal = err_illegal_r;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: queue-based reference model plus directed literal checks.
module tb_inst_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_kind;
  logic [4:0]  cmd_rs;
  logic [4:0]  cmd_rt;
  logic [4:0]  cmd_rd;
  logic [4:0]  cmd_shamt;
  logic [15:0] cmd_imm;
  logic [31:0] cmd_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [31:0] out_addr;
  logic [2:0]  level;
  logic        err_illegal;
  logic        err_range;

  inst_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
    .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_shamt(cmd_shamt),
    .cmd_imm(cmd_imm), .cmd_target(cmd_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_addr(out_addr),
    .level(level), .err_illegal(err_illegal), .err_range(err_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] word; logic [31:0] addr; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_wr_pc = BASE;
  bit          m_ill = 1'b0;
  bit          m_rng = 1'b0;
  bit          chk_en = 1'b0;

  // Returns {legal, word}; rng flags a bad absolute branch target.
  function automatic logic [32:0] model_enc(int k, int rs, int rt, int rd, int sh, int imm,
                                            logic [31:0] tgt, logic [31:0] pc, output bit rng);
    longint w;
    int     op;
    int     d;
    int     off;
    rng = 1'b0;
    w   = 0;
    op  = 0;
    case (k)
      0, 1, 2, 3, 4: w = longint'(rs) * 2097152 + rt * 65536 + rd * 2048 + ((k < 2) ? 32 + 2 * k : 34 + k);
      5, 6, 7:       w = longint'(rt) * 65536 + rd * 2048 + sh * 64 + ((k == 5) ? 0 : k - 4);
      8:             w = longint'(rs) * 2097152 + 8;
      9, 10, 11, 12, 13, 14, 15, 16, 17: begin
        case (k)
          9: op = 8;   10: op = 12; 11: op = 13; 12: op = 14;
          13: op = 35; 14: op = 43; 15: op = 4;  16: op = 5;
          default: op = 15;
        endcase
`ifdef INST_ENC_BRANCH_ABS_EN
        if (k == 15 || k == 16) begin
          d   = int'(tgt - (pc + 32'd4));
          off = d >>> 2;
          rng = (tgt % 4 != 0) || (off < -32768) || (off > 32767);
          imm = off & 32'h0000_FFFF;
        end
`endif
        w = longint'(op) * 67108864 + ((k == 17) ? 0 : rs) * 2097152 + rt * 65536 + (imm & 32'h0000_FFFF);
      end
      18, 19: w = longint'(k - 16) * 67108864 + (longint'(tgt) / 4) % 67108864;
      default: return 33'h0;
    endcase
    return {1'b1, w[31:0]};
  endfunction

  // Model update on the same edge the DUT samples.
  always @(posedge clk) begin
    bit          acc;
    bit          pop;
    bit          rng;
    logic [32:0] e;
    if (rst) begin
      mq.delete();
      m_wr_pc = BASE;
      m_ill   = 1'b0;
      m_rng   = 1'b0;
    end else if (clr) begin
      mq.delete();
      m_wr_pc = BASE;
    end else begin
      acc = cmd_valid && (mq.size() < DEPTH);
      pop = (mq.size() > 0) && out_ready;
      e   = model_enc(int'(cmd_kind), int'(cmd_rs), int'(cmd_rt), int'(cmd_rd),
                      int'(cmd_shamt), int'(cmd_imm), cmd_target, m_wr_pc, rng);
      if (pop) void'(mq.pop_front());
      if (acc) begin
        if (e[32]) begin
          mq.push_back('{e[31:0], m_wr_pc});
          m_wr_pc = m_wr_pc + 32'd4;
          if (rng) m_rng = 1'b1;
        end else begin
          m_ill = 1'b1;
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("level", 32'(level), 32'(mq.size()));
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      chk("cmd_ready", 32'(cmd_ready), 32'((mq.size() < DEPTH) && !clr));
      if (mq.size() > 0) begin
        chk("out_word", out_word, mq[0].word);
        chk("out_addr", out_addr, mq[0].addr);
      end
      chk("err_illegal", 32'(err_illegal), 32'(m_ill));
      chk("err_range", 32'(err_range), 32'(m_rng));
    end
  end

  // ---------------- stimulus ----------------
  task automatic back();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int k, int rs, int rt, int rd, int sh, int imm, logic [31:0] tgt);
    cmd_kind   = 5'(k);
    cmd_rs     = 5'(rs);
    cmd_rt     = 5'(rt);
    cmd_rd     = 5'(rd);
    cmd_shamt  = 5'(sh);
    cmd_imm    = 16'(imm);
    cmd_target = tgt;
  endtask

  task automatic send(int k, int rs, int rt, int rd, int sh, int imm, logic [31:0] tgt);
    bit r;
    bit ok;
    ok = 1'b0;
    drive(k, rs, rt, rd, sh, imm, tgt);
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      r = cmd_ready;
      back();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: kind %0d not accepted within 20 cycles", k);
    end
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    back();
    out_ready = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (mq.size() == 0) break;
      back();
    end
    out_ready = 1'b0;
    n_cmp++;
    if (mq.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d entries left, required 0", mq.size());
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; cmd_valid = 1'b0; out_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_word", out_word, 32'h0);
    chk("rst_addr", out_addr, BASE);
    chk("rst_err_illegal", 32'(err_illegal), 32'd0);
    chk("rst_err_range", 32'(err_range), 32'd0);
    back();
    rst = 1'b0;
    chk_en = 1'b1;

    // ADD: first word after reset, visible one cycle after accept
    send(0, 1, 2, 3, 0, 0, 32'h0);
    @(negedge clk);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_word", out_word, 32'h0022_1820);
    chk("add_addr", out_addr, 32'h0);
    back();
    drain();

    // back-to-back ADDI / SLL (rs ignored) / LW after rewinding
    clr = 1'b1; back(); clr = 1'b0;
    send(9, 0, 2, 0, 0, 5, 32'h0);
    send(5, 7, 2, 4, 3, 0, 32'h0);
    send(13, 6, 5, 0, 0, 8, 32'h0);
    @(negedge clk); chk("addi_word", out_word, 32'h2002_0005); chk("addi_addr", out_addr, 32'h0);
    pop_one();
    @(negedge clk); chk("sll_word", out_word, 32'h0002_20C0); chk("sll_addr", out_addr, 32'h4);
    pop_one();
    @(negedge clk); chk("lw_word", out_word, 32'h8CC5_0008); chk("lw_addr", out_addr, 32'h8);
    pop_one();

    // J, then an illegal kind
    send(18, 3, 3, 3, 3, 16'hFFFF, 32'h0040_0020);
    @(negedge clk); chk("j_word", out_word, 32'h0810_0008);
    back();
    drain();
    send(25, 1, 2, 3, 4, 5, 32'h0);
    @(negedge clk);
    chk("ill_flag", 32'(err_illegal), 32'd1);
    chk("ill_level", 32'(level), 32'd0);
    back();

    // every kind with scrambled fields, streaming
    out_ready = 1'b1;
    for (int k = 0; k < 22; k++) begin
      send(k, int'($urandom_range(31)), int'($urandom_range(31)), int'($urandom_range(31)),
           int'($urandom_range(31)), int'($urandom_range(16'hFFFF)), $urandom());
    end
    drain();

    // fill past capacity with the consumer stalled
    out_ready = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(0, 1, 2, i, 0, 0, 32'h0);
      back();
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("full_level", 32'(level), 32'(DEPTH));
    chk("full_ready", 32'(cmd_ready), 32'd0);
    chk("full_head", out_word, 32'h0022_0020);
    back();
    pop_one();
    pop_one();
    drive(1, 1, 1, 1, 0, 0, 32'h0);
    cmd_valid = 1'b1; out_ready = 1'b1;
    back();
    cmd_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk); chk("pushpop_level", 32'(level), 32'd2);
    back();
    drain();

    // flush with three entries queued
    send(2, 1, 1, 1, 0, 0, 32'h0);
    send(3, 2, 2, 2, 0, 0, 32'h0);
    send(4, 3, 3, 3, 0, 0, 32'h0);
    clr = 1'b1; back(); clr = 1'b0;
    @(negedge clk);
    chk("clr_level", 32'(level), 32'd0);
    chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_err_kept", 32'(err_illegal), 32'd1);
    back();
    send(0, 1, 2, 3, 0, 0, 32'h0);
    @(negedge clk); chk("clr_addr", out_addr, BASE); chk("clr_word", out_word, 32'h0022_1820);
    back();
    drain();

    // BEQ: same word in both builds (imm in default, absolute target when enabled)
    rst = 1'b1; back(); rst = 1'b0;
    send(0, 1, 2, 3, 0, 0, 32'h0);
    send(0, 1, 2, 3, 0, 0, 32'h0);
    send(15, 1, 2, 0, 0, 16'hFFFE, 32'h0000_0004);
    pop_one();
    pop_one();
    @(negedge clk);
    chk("beq_word", out_word, 32'h1022_FFFE);
    chk("beq_addr", out_addr, 32'h8);
    chk("beq_rng_clean", 32'(err_range), 32'd0);
    back();
    drain();
`ifdef INST_ENC_BRANCH_ABS_EN
    send(15, 1, 2, 0, 0, 0, 32'h0004_0000);
    @(negedge clk); chk("beq_far", 32'(err_range), 32'd1);
    back();
    drain();
    rst = 1'b1; back(); rst = 1'b0;
    send(0, 1, 2, 3, 0, 0, 32'h0);
    send(0, 1, 2, 3, 0, 0, 32'h0);
    send(15, 1, 2, 0, 0, 0, 32'h0000_0006);
    @(negedge clk); chk("beq_misalign", 32'(err_range), 32'd1);
    back();
    drain();
`endif

    repeat (3) back();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
